// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding, constants and helpers for the multiply/divide unit
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [5:0]  CNT_LAST    = 6'd31;
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    // Magnitude of a two's-complement word; -2^31 maps to 0x80000000 read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// rtl/multdiv_step.sv - one unsigned radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module multdiv_step
    import multdiv_pkg::*;
(
    input  logic        i_div,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Multiply: add multiplicand on lo[0] then shift {hi,lo} right.
    // Divide: shift {hi,lo} left, keep the trial subtraction if it did not borrow.
    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : 33'd0);
        w_shift = {i_hi, i_lo[31]};
        w_diff  = w_shift - {1'b0, i_b};
        if (i_div) begin
            if (!w_diff[32]) begin
                o_hi = w_diff[31:0];
                o_lo = {i_lo[30:0], 1'b1};
            end else begin
                o_hi = {i_hi[30:0], i_lo[31]};
                o_lo = {i_lo[30:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[32:1];
            o_lo = {w_sum[0], i_lo[31:1]};
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - iterative signed multiply/divide sequencer with register write-back (option: MULTDIV_EXC_EN)
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        exc
);

    state_e      r_state;
    state_e      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    logic        r_div;
    logic        r_neg;
    logic        r_dz;

    logic        w_start;
    logic        w_start_div;
    logic [31:0] w_step_hi;
    logic [31:0] w_step_lo;
    logic [31:0] w_low;

    // Multiply wins when both requests arrive together.
    assign w_start     = (r_state == IDLE) && (ctrl_mult || ctrl_div);
    assign w_start_div = ctrl_div && !ctrl_mult;

    // The core works on magnitudes; the low word of the negated product equals
    // the negated low word, so one negation serves both quotient and product.
    assign w_low = r_neg ? (~r_lo + 32'd1) : r_lo;

`ifdef MULTDIV_EXC_EN
    logic [63:0] w_prod_s;
    logic        w_ovf;
    assign w_prod_s = r_neg ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
    assign w_ovf    = (w_prod_s[63:32] != {32{w_prod_s[31]}});
`endif

    multdiv_step u_step (
        .i_div (r_div),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_b   (r_b),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state: divide-by-zero skips BUSY entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = (w_start_div && (op_b == 32'd0)) ? DONE : BUSY;
            BUSY: if (r_cnt == CNT_LAST) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture on start, one iteration per BUSY cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 6'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_b   <= 32'd0;
            r_rd  <= 5'd0;
            r_div <= 1'b0;
            r_neg <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_start) begin
            r_cnt <= 6'd0;
            r_hi  <= 32'd0;
            r_lo  <= w_start_div ? abs32(op_a) : abs32(op_b);
            r_b   <= w_start_div ? abs32(op_b) : abs32(op_a);
            r_rd  <= rd_in;
            r_div <= w_start_div;
            r_neg <= op_a[31] ^ op_b[31];
            r_dz  <= w_start_div && (op_b == 32'd0);
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 6'd1;
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
        end
    end

    // Outputs: stall while starting or iterating; write-back only in DONE.
    always_comb begin
        stall   = w_start || (r_state == BUSY);
        wb_we   = 1'b0;
        wb_reg  = 5'd0;
        wb_data = 32'd0;
        exc     = 1'b0;
        if (r_state == DONE) begin
            wb_we  = 1'b1;
            wb_reg = r_rd;
            if (r_dz) begin
`ifdef MULTDIV_EXC_EN
                wb_reg  = RSTATUS_REG;
                wb_data = EXC_DIV;
                exc     = 1'b1;
`else
                wb_data = 32'd0;
`endif
            end else begin
                wb_data = w_low;
`ifdef MULTDIV_EXC_EN
                if (!r_div && w_ovf) begin
                    wb_reg  = RSTATUS_REG;
                    wb_data = EXC_MULT;
                    exc     = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset_n;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        exc;

    int n_pass  = 0;
    int n_total = 0;

`ifdef MULTDIV_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    multdiv_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ctrl_mult (ctrl_mult),
        .ctrl_div  (ctrl_div),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .stall     (stall),
        .wb_we     (wb_we),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .exc       (exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input string sub, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: got %0h expected %0h", tag, sub, obs, exp);
    endtask

    // Start an op in cycle 0, optionally pulse ctrl_div at cycle inj, expect write-back at cycle lat.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int lat, input int inj,
                          input logic [4:0] ereg, input logic [31:0] edata, input logic eexc);
        tick();
        ctrl_mult = m;
        ctrl_div  = d;
        op_a      = a;
        op_b      = b;
        rd_in     = rd;
        #1;
        check(tag, "c0_stall_we", {62'd0, stall, wb_we}, 64'd2);
        for (int c = 1; c <= lat + 1; c++) begin
            tick();
            ctrl_mult = 1'b0;
            ctrl_div  = (c == inj);
            #1;
            if (c < lat) begin
                check(tag, "busy_stall_we_data", {30'd0, stall, wb_we, wb_data}, {30'd0, 1'b1, 1'b0, 32'd0});
            end else if (c == lat) begin
                check(tag, "done_stall_we_exc", {61'd0, stall, wb_we, exc}, {61'd0, 1'b0, 1'b1, eexc});
                check(tag, "done_reg", {59'd0, wb_reg}, {59'd0, ereg});
                check(tag, "done_data", {32'd0, wb_data}, {32'd0, edata});
            end else begin
                check(tag, "idle_after", {26'd0, stall, wb_we, exc, wb_reg, wb_data}, 64'd0);
            end
        end
    endtask

    initial begin
        logic saw_we;
        reset_n   = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        rd_in     = 5'd0;
        #2;
        check("reset", "outputs", {26'd0, stall, wb_we, exc, wb_reg, wb_data}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // 7 * -3 = -21
        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd3, 33, -1, 5'd3, 32'hFFFF_FFEB, 1'b0);
        // -7 / 2 = -3 (truncated toward zero)
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5, 33, -1, 5'd5, 32'hFFFF_FFFD, 1'b0);
        // -100 / 7 = -14
        run_op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd11, 33, -1, 5'd11, 32'hFFFF_FFF2, 1'b0);
        // 9 / 0 exits after one cycle
        run_op("div_9_0", 1'b0, 1'b1, 32'd9, 32'd0, 5'd7, 1, -1,
               EXC_EN ? 5'd30 : 5'd7, EXC_EN ? 32'd5 : 32'd0, EXC_EN);
        // 0x10000 * 0x10000 overflows, low word 0
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd8, 33, -1,
               EXC_EN ? 5'd30 : 5'd8, EXC_EN ? 32'd4 : 32'd0, EXC_EN);
        // -2^31 * -1 overflows, low word 0x80000000
        run_op("mul_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 33, -1,
               EXC_EN ? 5'd30 : 5'd9, EXC_EN ? 32'd4 : 32'h8000_0000, EXC_EN);
        // 0x7FFFFFFF * -1 fits
        run_op("mul_max_m1", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd10, 33, -1, 5'd10, 32'h8000_0001, 1'b0);
        // -2^31 / -1 = 0x80000000, no exception
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 33, -1, 5'd12, 32'h8000_0000, 1'b0);
        // ctrl_div pulsed in cycle 10 of a busy multiply is ignored
        run_op("mul_ign_div", 1'b1, 1'b0, 32'd6, 32'd3, 5'd13, 33, 10, 5'd13, 32'd18, 1'b0);
        // both starts together: multiply wins
        run_op("both_start", 1'b1, 1'b1, 32'd6, 32'd3, 5'd4, 33, -1, 5'd4, 32'd18, 1'b0);

        // reset in cycle 15 of a divide abandons it
        tick();
        ctrl_div = 1'b1;
        op_a     = 32'd100;
        op_b     = 32'd7;
        rd_in    = 5'd14;
        for (int c = 1; c <= 15; c++) begin
            tick();
            ctrl_div = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid", "outputs", {26'd0, stall, wb_we, exc, wb_reg, wb_data}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        saw_we = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            #1;
            saw_we = saw_we | wb_we | stall;
        end
        check("rst_mid", "no_wb_after", {63'd0, saw_we}, 64'd0);
        run_op("after_rst", 1'b0, 1'b1, 32'd100, 32'd7, 5'd15, 33, -1, 5'd15, 32'd14, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
